// File: rtl/pwm_pkg.sv
// Shared encodings and default sizing for the multi-channel PWM block.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam int PWM_DEFAULT_WIDTH    = 8;
    localparam int PWM_DEFAULT_CHANNELS = 4;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: up or up/down counter with period/mode latched only at
// period boundaries, plus boundary detection and the period_start flag.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] counter,
    output logic             boundary,
    output logic             period_start
);

    pwm_dir_e         dir, dir_next;
    pwm_mode_e        mode_active, mode_eff;
    logic [WIDTH-1:0] period_active, period_eff, counter_next;
    logic             transfer, zero_q;

    assign boundary     = enable && (counter == '0);
    assign transfer     = boundary || !enable;
    assign period_start = enable && zero_q;

    // The step out of a boundary cycle already obeys the freshly sampled period/mode,
    // so a new period of 0 holds the counter at 0 instead of overshooting it.
    assign period_eff = boundary ? period : period_active;
    assign mode_eff   = boundary ? pwm_mode_e'(mode) : mode_active;

    always_comb begin
        counter_next = counter + WIDTH'(1);
        dir_next     = dir;
        if (!enable) begin
            counter_next = '0;
            dir_next     = DIR_UP;
        end else if (dir == DIR_DOWN ||
                     (counter >= period_eff && mode_eff == PWM_CENTER && period_eff != '0)) begin
            counter_next = counter - WIDTH'(1);
            dir_next     = (counter == WIDTH'(1)) ? DIR_UP : DIR_DOWN;
        end else if (counter >= period_eff) begin
            counter_next = '0;
            dir_next     = DIR_UP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter       <= '0;
            dir           <= DIR_UP;
            period_active <= '1;
            mode_active   <= PWM_EDGE;
            zero_q        <= 1'b0;
        end else begin
            counter <= counter_next;
            dir     <= dir_next;
            zero_q  <= (counter_next == '0);
            if (transfer) begin
                period_active <= period;
                mode_active   <= pwm_mode_e'(mode);
            end
        end
    end

endmodule

// File: rtl/multi_channel_pwm.sv
// Multi-channel PWM: shadowed duty registers per channel compared against a
// shared timebase; shadows move to active only at period boundaries or while idle.
module multi_channel_pwm
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_DEFAULT_WIDTH,
    parameter int CHANNELS = PWM_DEFAULT_CHANNELS,
    localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                mode,
    input  logic [WIDTH-1:0]    period,
    input  logic                duty_wr_en,
    input  logic [CH_BITS-1:0]  duty_wr_ch,
    input  logic [WIDTH-1:0]    duty_wr_data,
    output logic [WIDTH-1:0]    counter,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic                update_pending
);

    localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS + 1)'(CHANNELS);

    logic boundary, transfer, wr_valid;

    pwm_timebase #(
        .WIDTH(WIDTH)
    ) u_timebase (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .mode         (mode),
        .period       (period),
        .counter      (counter),
        .boundary     (boundary),
        .period_start (period_start)
    );

    assign transfer = boundary || !enable;
    assign wr_valid = duty_wr_en && ({1'b0, duty_wr_ch} < CH_LIMIT);

    // A write landing in a transfer cycle keeps the flag set for the next boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            update_pending <= 1'b0;
        end else if (wr_valid) begin
            update_pending <= 1'b1;
        end else if (transfer) begin
            update_pending <= 1'b0;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] duty_shadow, duty_active;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                duty_shadow <= '0;
                duty_active <= '0;
            end else begin
                if (wr_valid && duty_wr_ch == CH_BITS'(i)) begin
                    duty_shadow <= duty_wr_data;
                end
                if (transfer) begin
                    duty_active <= duty_shadow;
                end
            end
        end

        assign pwm_out[i] = enable && (counter < duty_active);
    end

endmodule

// File: tb/tb_multi_channel_pwm.sv
// Scoreboard bench for multi_channel_pwm: directed stimulus queues per-cycle
// expectations, a negedge monitor compares whatever is due in that cycle.
module tb_multi_channel_pwm;

    localparam int SEL_CNT   = 0;
    localparam int SEL_PWM   = 1;
    localparam int SEL_PS    = 2;
    localparam int SEL_PEND  = 3;
    localparam int SEL_PWM2  = 4;
    localparam int SEL_PEND2 = 5;

    typedef struct {
        int    cyc;
        int    sel;
        int    exp;
        string name;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable, mode;
    logic [7:0] period;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_data;
    logic [7:0] counter;
    logic [3:0] pwm_out;
    logic       period_start, update_pending;

    logic       enable2, mode2;
    logic [7:0] period2;
    logic       wr_en2;
    logic [1:0] wr_ch2;
    logic [7:0] wr_data2;
    logic [7:0] counter2;
    logic [2:0] pwm_out2;
    logic       period_start2, update_pending2;

    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;
    int       act;
    sb_item_t sb[$];
    sb_item_t sb_keep[$];

    multi_channel_pwm #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .mode           (mode),
        .period         (period),
        .duty_wr_en     (wr_en),
        .duty_wr_ch     (wr_ch),
        .duty_wr_data   (wr_data),
        .counter        (counter),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .update_pending (update_pending)
    );

    multi_channel_pwm #(.WIDTH(8), .CHANNELS(3)) dut3 (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable2),
        .mode           (mode2),
        .period         (period2),
        .duty_wr_en     (wr_en2),
        .duty_wr_ch     (wr_ch2),
        .duty_wr_data   (wr_data2),
        .counter        (counter2),
        .pwm_out        (pwm_out2),
        .period_start   (period_start2),
        .update_pending (update_pending2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int sample(input int sel);
        case (sel)
            SEL_CNT:   return int'(counter);
            SEL_PWM:   return int'(pwm_out);
            SEL_PS:    return int'(period_start);
            SEL_PEND:  return int'(update_pending);
            SEL_PWM2:  return int'(pwm_out2);
            SEL_PEND2: return int'(update_pending2);
            default:   return -1;
        endcase
    endfunction

    // Compare every expectation due in this cycle; anything overdue is an error
    always @(negedge clk) begin
        sb_keep.delete();
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                act = sample(sb[i].sel);
                checks++;
                if (act != sb[i].exp) begin
                    errors++;
                    $display("[TB] FAIL %s cycle %0d: got %0d expected %0d",
                             sb[i].name, cyc, act, sb[i].exp);
                end
            end else if (sb[i].cyc < cyc) begin
                errors++;
                $display("[TB] FAIL %s never compared (due cycle %0d)", sb[i].name, sb[i].cyc);
            end else begin
                sb_keep.push_back(sb[i]);
            end
        end
        sb = sb_keep;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int sel, input int off, input int exp, input string name);
        sb_item_t it;
        it.cyc  = cyc + off;
        it.sel  = sel;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic applyStimulus(input logic en, input logic md, input logic [7:0] per);
        enable = en;
        mode   = md;
        period = per;
    endtask

    task automatic writeDuty(input logic we, input logic [1:0] ch, input logic [7:0] d);
        wr_en   = we;
        wr_ch   = ch;
        wr_data = d;
    endtask

    task automatic writeDuty2(input logic we, input logic [1:0] ch, input logic [7:0] d);
        wr_en2   = we;
        wr_ch2   = ch;
        wr_data2 = d;
    endtask

    initial begin
        int c;
        int e;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd9);
        writeDuty(1'b0, 2'd0, 8'd0);
        enable2 = 1'b0;
        mode2   = 1'b0;
        period2 = 8'd0;
        writeDuty2(1'b0, 2'd0, 8'd0);
        step(3);

        // Bring-up, then async reset in the middle of a period with ch0 high
        reset = 1'b1;
        writeDuty(1'b1, 2'd0, 8'd3);
        checkOutput(SEL_CNT, 0, 0, "a0_cnt");
        checkOutput(SEL_PEND, 0, 0, "a0_pend");
        step(1);
        applyStimulus(1'b1, 1'b0, 8'd9);
        writeDuty(1'b1, 2'd1, 8'd7);
        checkOutput(SEL_CNT, 0, 0, "a1_cnt");
        checkOutput(SEL_PS, 0, 1, "a1_ps");
        checkOutput(SEL_PEND, 0, 1, "a1_pend");
        checkOutput(SEL_PWM, 0, 'b0000, "a1_pwm");
        checkOutput(SEL_CNT, 1, 1, "a2_cnt");
        checkOutput(SEL_PWM, 1, 'b0001, "a2_pwm");
        checkOutput(SEL_PEND, 1, 1, "a2_pend");
        step(1);
        writeDuty(1'b0, 2'd0, 8'd0);
        step(1);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd9);
        checkOutput(SEL_CNT, 0, 0, "rst_cnt");
        checkOutput(SEL_PWM, 0, 'b0000, "rst_pwm");
        checkOutput(SEL_PEND, 0, 0, "rst_pend");
        checkOutput(SEL_PS, 0, 0, "rst_ps");
        step(2);

        // Idle writes: ch0=3 ch1=0 ch2=10 ch3=5, then run edge mode period 9
        reset = 1'b1;
        writeDuty(1'b1, 2'd0, 8'd3);
        checkOutput(SEL_CNT, 0, 0, "r0_cnt");
        checkOutput(SEL_PEND, 0, 0, "r0_pend");
        step(1);
        writeDuty(1'b1, 2'd1, 8'd0);
        checkOutput(SEL_PEND, 0, 1, "r1_pend");
        step(1);
        writeDuty(1'b1, 2'd2, 8'd10);
        step(1);
        writeDuty(1'b1, 2'd3, 8'd5);
        step(1);
        writeDuty(1'b0, 2'd0, 8'd0);
        applyStimulus(1'b1, 1'b0, 8'd9);
        checkOutput(SEL_PEND, 0, 1, "r4_pend");
        checkOutput(SEL_PEND, 1, 0, "r5_pend");
        for (int j = 0; j < 20; j++) begin
            c = j % 10;
            e = (c < 3 ? 1 : 0) + 4 + ((c < 5 && j >= 1) ? 8 : 0);
            checkOutput(SEL_CNT, j, c, "edge_cnt");
            checkOutput(SEL_PS, j, (c == 0) ? 1 : 0, "edge_ps");
            checkOutput(SEL_PWM, j, e, "edge_pwm");
        end
        step(24);

        // Shadow write mid-period (counter 4): current period keeps duty 3
        writeDuty(1'b1, 2'd0, 8'd7);
        checkOutput(SEL_CNT, 0, 4, "sh_cnt");
        checkOutput(SEL_PEND, 0, 0, "sh_pend0");
        for (int j = 1; j <= 5; j++) begin
            checkOutput(SEL_PWM, j, 'b0100, "sh_old_pwm");
            checkOutput(SEL_PEND, j, 1, "sh_pend");
        end
        checkOutput(SEL_PS, 6, 1, "sh_bnd_ps");
        checkOutput(SEL_PEND, 6, 1, "sh_bnd_pend");
        checkOutput(SEL_PWM, 6, 'b1101, "sh_bnd_pwm");
        checkOutput(SEL_PEND, 7, 0, "sh_clr_pend");
        checkOutput(SEL_PWM, 7, 'b1101, "sh_new_c1");
        checkOutput(SEL_PWM, 12, 'b0101, "sh_new_c6");
        checkOutput(SEL_PWM, 13, 'b0100, "sh_new_c7");
        step(1);
        writeDuty(1'b0, 2'd0, 8'd0);
        step(15);

        // Write in a boundary cycle is deferred by one period
        writeDuty(1'b1, 2'd0, 8'd2);
        checkOutput(SEL_CNT, 0, 0, "bw_cnt");
        checkOutput(SEL_PS, 0, 1, "bw_ps");
        checkOutput(SEL_PEND, 0, 0, "bw_pend0");
        checkOutput(SEL_PEND, 1, 1, "bw_pend1");
        checkOutput(SEL_PWM, 6, 'b0101, "bw_keep_c6");
        checkOutput(SEL_PWM, 7, 'b0100, "bw_keep_c7");
        checkOutput(SEL_PEND, 10, 1, "bw_pend_bnd");
        checkOutput(SEL_PWM, 10, 'b1101, "bw_bnd_pwm");
        checkOutput(SEL_PEND, 11, 0, "bw_pend_clr");
        checkOutput(SEL_PWM, 11, 'b1101, "bw_new_c1");
        checkOutput(SEL_PWM, 12, 'b1100, "bw_new_c2");
        step(1);
        writeDuty(1'b0, 2'd0, 8'd0);
        step(25);

        // Period 9 -> 4 requested at counter 6 takes effect after reaching 9
        applyStimulus(1'b1, 1'b0, 8'd4);
        checkOutput(SEL_CNT, 0, 6, "pc_c6");
        checkOutput(SEL_CNT, 1, 7, "pc_c7");
        checkOutput(SEL_CNT, 2, 8, "pc_c8");
        checkOutput(SEL_CNT, 3, 9, "pc_c9");
        checkOutput(SEL_PS, 3, 0, "pc_ps9");
        checkOutput(SEL_CNT, 4, 0, "pc_wrap");
        checkOutput(SEL_PS, 4, 1, "pc_ps0");
        checkOutput(SEL_PWM, 5, 'b1101, "pc_pwm1");
        checkOutput(SEL_PWM, 6, 'b1100, "pc_pwm2");
        checkOutput(SEL_CNT, 8, 4, "pc_top4");
        checkOutput(SEL_PWM, 8, 'b1100, "pc_pwm4");
        checkOutput(SEL_CNT, 9, 0, "pc_wrap4");
        checkOutput(SEL_PS, 9, 1, "pc_ps5");
        checkOutput(SEL_CNT, 11, 2, "pc_c2");
        step(11);

        // Drop enable at counter 2; program center mode while idle
        applyStimulus(1'b0, 1'b1, 8'd8);
        writeDuty(1'b1, 2'd0, 8'd4);
        checkOutput(SEL_CNT, 1, 0, "dis_cnt");
        checkOutput(SEL_PWM, 1, 'b0000, "dis_pwm");
        checkOutput(SEL_PS, 1, 0, "dis_ps");
        checkOutput(SEL_PEND, 1, 1, "dis_pend");
        checkOutput(SEL_PEND, 2, 0, "idle_pend_clr");
        step(1);
        writeDuty(1'b0, 2'd0, 8'd0);
        step(2);

        // Re-enable in center mode, period 8, ch0=4
        applyStimulus(1'b1, 1'b1, 8'd8);
        for (int j = 0; j <= 16; j++) begin
            c = (j <= 8) ? j : 16 - j;
            e = (c < 4 ? 1 : 0) + 4 + (c < 5 ? 8 : 0);
            checkOutput(SEL_CNT, j, c, "ctr_cnt");
            checkOutput(SEL_PS, j, (c == 0) ? 1 : 0, "ctr_ps");
            checkOutput(SEL_PWM, j, e, "ctr_pwm");
        end
        step(16);

        // Period 0: counter pinned at 0, every cycle a boundary
        applyStimulus(1'b1, 1'b0, 8'd0);
        for (int j = 1; j <= 3; j++) begin
            checkOutput(SEL_CNT, j, 0, "p0_cnt");
            checkOutput(SEL_PS, j, 1, "p0_ps");
            checkOutput(SEL_PWM, j, 'b1101, "p0_pwm");
        end
        step(3);

        // Three-channel instance: channel 3 is out of range
        enable2 = 1'b1;
        writeDuty2(1'b1, 2'd3, 8'd9);
        checkOutput(SEL_PWM2, 0, 0, "ill_pwm0");
        checkOutput(SEL_PEND2, 1, 0, "ill_pend");
        step(1);
        writeDuty2(1'b1, 2'd2, 8'd9);
        checkOutput(SEL_PWM2, 1, 0, "ill_pwm1");
        checkOutput(SEL_PEND2, 1, 1, "ok_pend");
        checkOutput(SEL_PWM2, 2, 'b100, "ok_pwm");
        checkOutput(SEL_PEND2, 2, 0, "ok_pend_clr");
        step(1);
        writeDuty2(1'b0, 2'd0, 8'd0);
        step(4);

        if (sb.size() != 0) begin
            foreach (sb[i]) begin
                errors++;
                $display("[TB] FAIL %s left unchecked (due cycle %0d)", sb[i].name, sb[i].cyc);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
